// File: rtl/basic_cpu_pkg.sv
// rtl/basic_cpu_pkg.sv - shared codes and types for the basic-computer control unit
// Purpose: bus-source and ALU codes, opcode and instruction-bit positions,
//          control-state enum and the bundled strobe struct.
// Ports:   none (package).
package basic_cpu_pkg;

  localparam logic [2:0] MUX_ZERO = 3'd0;
  localparam logic [2:0] MUX_AR   = 3'd1;
  localparam logic [2:0] MUX_PC   = 3'd2;
  localparam logic [2:0] MUX_DR   = 3'd3;
  localparam logic [2:0] MUX_AC   = 3'd4;
  localparam logic [2:0] MUX_IR   = 3'd5;
  localparam logic [2:0] MUX_TR   = 3'd6;
  localparam logic [2:0] MUX_MEM  = 3'd7;

  localparam logic [2:0] ALU_AND     = 3'd0;
  localparam logic [2:0] ALU_ADD     = 3'd1;
  localparam logic [2:0] ALU_PASS_DR = 3'd2;
  localparam logic [2:0] ALU_CMA     = 3'd3;
  localparam logic [2:0] ALU_CIR     = 3'd4;
  localparam logic [2:0] ALU_CIL     = 3'd5;
  localparam logic [2:0] ALU_PASS_AC = 3'd6;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_LDA    = 3'd2;
  localparam logic [2:0] OP_STA    = 3'd3;
  localparam logic [2:0] OP_BUN    = 3'd4;
  localparam logic [2:0] OP_BSA    = 3'd5;
  localparam logic [2:0] OP_ISZ    = 3'd6;
  localparam logic [2:0] OP_REG_IO = 3'd7;

  // Register-reference bit positions within IR[11:0]
  localparam int RB_CLA = 11;
  localparam int RB_CLE = 10;
  localparam int RB_CMA = 9;
  localparam int RB_CME = 8;
  localparam int RB_CIR = 7;
  localparam int RB_CIL = 6;
  localparam int RB_INC = 5;
  localparam int RB_SPA = 4;
  localparam int RB_SNA = 3;
  localparam int RB_SZA = 2;
  localparam int RB_SZE = 1;
  localparam int RB_HLT = 0;

  // I/O bit positions within IR[11:0] (INP, OUT, SKO are no-ops here)
  localparam int IB_SKI = 9;
  localparam int IB_ION = 7;
  localparam int IB_IOF = 6;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RUN
  } ctrl_state_t;

  typedef struct packed {
    logic       mem_we;
    logic [2:0] mux_sel;
    logic [2:0] alu_op;
    logic load_ar, inc_ar, clr_ar;
    logic load_pc, inc_pc, clr_pc;
    logic load_dr, inc_dr, clr_dr;
    logic load_ac, inc_ac, clr_ac;
    logic load_e, inc_e, clr_e;
    logic load_ien, clr_ien;
    logic load_r, clr_r;
    logic inc_start, clr_start;
    logic load_ir, clr_ir;
    logic load_tr, clr_tr;
  } ctrl_t;

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - 3-bit timing sequence counter with one-hot T decode
// Purpose: holds the current T step; clr wins over inc.
// Ports:   clk, rst (async, active-high), clr, inc -> count[2:0], t[6:0] (one-hot T0..T6,
//          all zero when count is the unreachable value 7).
module seq_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] count,
  output logic [6:0] t
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 3'd0;
    end else if (clr) begin
      count <= 3'd0;
    end else if (inc) begin
      count <= count + 3'd1;
    end
  end

  always_comb begin
    t = '0;
    for (int k = 0; k < 7; k++) begin
      t[k] = (count == 3'(k));
    end
  end

endmodule

// File: rtl/basic_control_unit.sv
// rtl/basic_control_unit.sv - hardwired control unit for the basic-computer datapath
// Purpose: INIT/IDLE/RUN sequencing, fetch/decode/indirect/execute and interrupt
//          cycles driving every datapath strobe.
// Ports:   clk, reset (async, active-high), run_req; status IR/AC/DR [DW-1:0],
//          E, start, IEN_out, R_out, FGI; outputs mem_we, mux_sel[2:0], alu_op[2:0],
//          load/inc/clr strobes for AR, PC, DR, AC, E, IEN, R, start, plus
//          load/clr for IR and TR, and sc[2:0] (current T index).
module basic_control_unit
  import basic_cpu_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_req,
  input  logic [DW-1:0] IR,
  input  logic [DW-1:0] AC,
  input  logic [DW-1:0] DR,
  input  logic          E,
  input  logic          start,
  input  logic          IEN_out,
  input  logic          R_out,
  input  logic          FGI,
  output logic          mem_we,
  output logic [2:0]    mux_sel,
  output logic [2:0]    alu_op,
  output logic          load_AR, inc_AR, clr_AR,
  output logic          load_PC, inc_PC, clr_PC,
  output logic          load_DR, inc_DR, clr_DR,
  output logic          load_AC, inc_AC, clr_AC,
  output logic          load_E, inc_E, clr_E,
  output logic          load_IEN, inc_IEN, clr_IEN,
  output logic          load_R, inc_R, clr_R,
  output logic          load_start, inc_start, clr_start,
  output logic          load_IR, clr_IR,
  output logic          load_TR, clr_TR,
  output logic [2:0]    sc
);

  ctrl_state_t state, state_nx;
  ctrl_t       c;
  logic        i_bit;
  logic        int_cyc;
  logic        sc_clr, sc_inc;
  logic        latch_i, latch_int;
  logic        is_int;
  logic [6:0]  t;
  logic [2:0]  d;
  logic [AW-1:0] ir_bits;

  assign d       = IR[DW-2 -: 3];
  assign ir_bits = IR[AW-1:0];

  seq_counter u_sc (
    .clk   (clk),
    .rst   (reset),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc),
    .t     (t)
  );

  // The fetch/interrupt choice is made at T0 and held: load_R may set R during
  // a fetch, and that fetch must still complete before the interrupt cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      i_bit   <= 1'b0;
      int_cyc <= 1'b0;
    end else begin
      state <= state_nx;
      if (latch_i) begin
        i_bit <= IR[DW-1];
      end
      if (latch_int) begin
        int_cyc <= R_out;
      end
    end
  end

  always_comb begin
    c         = '0;
    state_nx  = state;
    sc_clr    = 1'b0;
    sc_inc    = 1'b0;
    latch_i   = 1'b0;
    latch_int = 1'b0;
    is_int    = t[0] ? R_out : int_cyc;

    case (state)
      ST_INIT: begin
        c.clr_ar    = 1'b1;
        c.clr_pc    = 1'b1;
        c.clr_dr    = 1'b1;
        c.clr_ac    = 1'b1;
        c.clr_e     = 1'b1;
        c.clr_ir    = 1'b1;
        c.clr_tr    = 1'b1;
        c.clr_ien   = 1'b1;
        c.clr_r     = 1'b1;
        c.clr_start = 1'b1;
        sc_clr      = 1'b1;
        state_nx    = ST_IDLE;
      end

      ST_IDLE: begin
        sc_clr = 1'b1;
        if (start) begin
          state_nx = ST_RUN;
        end else if (run_req) begin
          c.inc_start = 1'b1;
        end
      end

      ST_RUN: begin
        if (sc == 3'd7) begin
          sc_clr = 1'b1;
        end else if (t[0] && !start) begin
          state_nx = ST_IDLE;
          sc_clr   = 1'b1;
        end else begin
          sc_inc = 1'b1;

          if ((t[0] || t[1] || t[2]) && !R_out && IEN_out && FGI) begin
            c.load_r = 1'b1;
          end

          if (t[0]) begin
            latch_int = 1'b1;
            c.mux_sel = MUX_PC;
            if (R_out) begin
              c.clr_ar  = 1'b1;
              c.load_tr = 1'b1;
            end else begin
              c.load_ar = 1'b1;
            end
          end

          if (t[1]) begin
            if (is_int) begin
              c.mux_sel = MUX_TR;
              c.mem_we  = 1'b1;
              c.clr_pc  = 1'b1;
            end else begin
              c.mux_sel = MUX_MEM;
              c.load_ir = 1'b1;
              c.inc_pc  = 1'b1;
            end
          end

          if (t[2]) begin
            if (is_int) begin
              c.inc_pc  = 1'b1;
              c.clr_ien = 1'b1;
              c.clr_r   = 1'b1;
              sc_clr    = 1'b1;
            end else begin
              c.mux_sel = MUX_IR;
              c.load_ar = 1'b1;
              latch_i   = 1'b1;
            end
          end

          if (t[3]) begin
            if (d != OP_REG_IO) begin
              if (i_bit) begin
                c.mux_sel = MUX_MEM;
                c.load_ar = 1'b1;
              end
            end else begin
              sc_clr = 1'b1;
              if (!i_bit) begin
                if (ir_bits[RB_CLA]) c.clr_ac = 1'b1;
                if (ir_bits[RB_CLE]) c.clr_e  = 1'b1;
                if (ir_bits[RB_CMA]) begin
                  c.alu_op  = ALU_CMA;
                  c.load_ac = 1'b1;
                end
                if (ir_bits[RB_CME]) c.inc_e = 1'b1;
                if (ir_bits[RB_CIR]) begin
                  c.alu_op  = ALU_CIR;
                  c.load_ac = 1'b1;
                  c.load_e  = 1'b1;
                end
                if (ir_bits[RB_CIL]) begin
                  c.alu_op  = ALU_CIL;
                  c.load_ac = 1'b1;
                  c.load_e  = 1'b1;
                end
                if (ir_bits[RB_INC]) c.inc_ac = 1'b1;
                // Skip conditions OR together so any combination yields one skip.
                c.inc_pc = (ir_bits[RB_SPA] && !AC[DW-1]) ||
                           (ir_bits[RB_SNA] &&  AC[DW-1]) ||
                           (ir_bits[RB_SZA] && (AC == '0)) ||
                           (ir_bits[RB_SZE] && !E);
                if (ir_bits[RB_HLT]) c.clr_start = 1'b1;
              end else begin
                c.inc_pc = ir_bits[IB_SKI] && FGI;
                if (ir_bits[IB_ION]) c.load_ien = 1'b1;
                if (ir_bits[IB_IOF]) c.clr_ien  = 1'b1;
              end
            end
          end

          if (t[4]) begin
            case (d)
              OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                c.mux_sel = MUX_MEM;
                c.load_dr = 1'b1;
              end
              OP_STA: begin
                c.mux_sel = MUX_AC;
                c.mem_we  = 1'b1;
                sc_clr    = 1'b1;
              end
              OP_BUN: begin
                c.mux_sel = MUX_AR;
                c.load_pc = 1'b1;
                sc_clr    = 1'b1;
              end
              OP_BSA: begin
                c.mux_sel = MUX_PC;
                c.mem_we  = 1'b1;
                c.inc_ar  = 1'b1;
              end
              default: sc_clr = 1'b1;
            endcase
          end

          if (t[5]) begin
            case (d)
              OP_AND: begin
                c.alu_op  = ALU_AND;
                c.load_ac = 1'b1;
                sc_clr    = 1'b1;
              end
              OP_ADD: begin
                c.alu_op  = ALU_ADD;
                c.load_ac = 1'b1;
                c.load_e  = 1'b1;
                sc_clr    = 1'b1;
              end
              OP_LDA: begin
                c.alu_op  = ALU_PASS_DR;
                c.load_ac = 1'b1;
                sc_clr    = 1'b1;
              end
              OP_BSA: begin
                c.mux_sel = MUX_AR;
                c.load_pc = 1'b1;
                sc_clr    = 1'b1;
              end
              OP_ISZ: c.inc_dr = 1'b1;
              default: sc_clr = 1'b1;
            endcase
          end

          if (t[6]) begin
            sc_clr = 1'b1;
            if (d == OP_ISZ) begin
              // DR already holds the incremented value here.
              c.mux_sel = MUX_DR;
              c.mem_we  = 1'b1;
              c.inc_pc  = (DR == '0);
            end
          end
        end
      end

      default: state_nx = ST_INIT;
    endcase

    if (reset) begin
      c = '0;
    end
  end

  assign mem_we     = c.mem_we;
  assign mux_sel    = c.mux_sel;
  assign alu_op     = c.alu_op;
  assign load_AR    = c.load_ar;
  assign inc_AR     = c.inc_ar;
  assign clr_AR     = c.clr_ar;
  assign load_PC    = c.load_pc;
  assign inc_PC     = c.inc_pc;
  assign clr_PC     = c.clr_pc;
  assign load_DR    = c.load_dr;
  assign inc_DR     = c.inc_dr;
  assign clr_DR     = c.clr_dr;
  assign load_AC    = c.load_ac;
  assign inc_AC     = c.inc_ac;
  assign clr_AC     = c.clr_ac;
  assign load_E     = c.load_e;
  assign inc_E      = c.inc_e;
  assign clr_E      = c.clr_e;
  assign load_IEN   = c.load_ien;
  assign inc_IEN    = 1'b0;
  assign clr_IEN    = c.clr_ien;
  assign load_R     = c.load_r;
  assign inc_R      = 1'b0;
  assign clr_R      = c.clr_r;
  assign load_start = 1'b0;
  assign inc_start  = c.inc_start;
  assign clr_start  = c.clr_start;
  assign load_IR    = c.load_ir;
  assign clr_IR     = c.clr_ir;
  assign load_TR    = c.load_tr;
  assign clr_TR     = c.clr_tr;

endmodule

// File: tb/tb_basic_control_unit.sv
// tb/tb_basic_control_unit.sv - directed self-checking bench for basic_control_unit
module tb_basic_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_req = 1'b0;
  logic FGI = 1'b0;
  logic load_img = 1'b0;

  logic [11:0] ar, pc;
  logic [15:0] ir, ac, dr, tr;
  logic        e, ien, r, st;
  logic [15:0] mem [0:4095];
  logic [15:0] img [0:4095];
  logic [15:0] bus, alu_y;
  logic        alu_c;

  logic       mem_we;
  logic [2:0] mux_sel, alu_op, sc;
  logic load_AR, inc_AR, clr_AR, load_PC, inc_PC, clr_PC;
  logic load_DR, inc_DR, clr_DR, load_AC, inc_AC, clr_AC;
  logic load_E, inc_E, clr_E, load_IEN, inc_IEN, clr_IEN;
  logic load_R, inc_R, clr_R, load_start, inc_start, clr_start;
  logic load_IR, clr_IR, load_TR, clr_TR;

  logic [9:0]  clr_vec;
  logic [24:0] other_vec;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc;

  always #5 clk = ~clk;

  basic_control_unit #(.AW(12), .DW(16)) dut (
    .clk(clk), .reset(reset), .run_req(run_req),
    .IR(ir), .AC(ac), .DR(dr), .E(e), .start(st),
    .IEN_out(ien), .R_out(r), .FGI(FGI),
    .mem_we(mem_we), .mux_sel(mux_sel), .alu_op(alu_op),
    .load_AR(load_AR), .inc_AR(inc_AR), .clr_AR(clr_AR),
    .load_PC(load_PC), .inc_PC(inc_PC), .clr_PC(clr_PC),
    .load_DR(load_DR), .inc_DR(inc_DR), .clr_DR(clr_DR),
    .load_AC(load_AC), .inc_AC(inc_AC), .clr_AC(clr_AC),
    .load_E(load_E), .inc_E(inc_E), .clr_E(clr_E),
    .load_IEN(load_IEN), .inc_IEN(inc_IEN), .clr_IEN(clr_IEN),
    .load_R(load_R), .inc_R(inc_R), .clr_R(clr_R),
    .load_start(load_start), .inc_start(inc_start), .clr_start(clr_start),
    .load_IR(load_IR), .clr_IR(clr_IR),
    .load_TR(load_TR), .clr_TR(clr_TR),
    .sc(sc)
  );

  assign clr_vec = {clr_AR, clr_PC, clr_DR, clr_AC, clr_E, clr_IR, clr_TR,
                    clr_IEN, clr_R, clr_start};
  assign other_vec = {load_AR, inc_AR, load_PC, inc_PC, load_DR, inc_DR,
                      load_AC, inc_AC, load_E, inc_E, load_IEN, inc_IEN,
                      load_R, inc_R, load_start, inc_start, load_IR, load_TR,
                      mem_we, mux_sel, alu_op};

  // Datapath model: bus, ALU, registers and memory
  always_comb begin
    bus = 16'h0000;
    case (mux_sel)
      3'd1: bus = {4'h0, ar};
      3'd2: bus = {4'h0, pc};
      3'd3: bus = dr;
      3'd4: bus = ac;
      3'd5: bus = ir;
      3'd6: bus = tr;
      3'd7: bus = mem[ar];
      default: bus = 16'h0000;
    endcase
  end

  always_comb begin
    alu_y = ac;
    alu_c = e;
    case (alu_op)
      3'd0: alu_y = ac & dr;
      3'd1: {alu_c, alu_y} = {1'b0, ac} + {1'b0, dr};
      3'd2: alu_y = dr;
      3'd3: alu_y = ~ac;
      3'd4: begin alu_y = {e, ac[15:1]}; alu_c = ac[0]; end
      3'd5: begin alu_y = {ac[14:0], e}; alu_c = ac[15]; end
      default: alu_y = ac;
    endcase
  end

  always @(posedge clk) begin
    if (load_img) begin
      for (int k = 0; k < 4096; k++) mem[k] <= img[k];
    end else if (mem_we) begin
      mem[ar] <= bus;
    end
    if (clr_AR) ar <= 12'h0; else if (load_AR) ar <= bus[11:0]; else if (inc_AR) ar <= ar + 12'h1;
    if (clr_PC) pc <= 12'h0; else if (load_PC) pc <= bus[11:0]; else if (inc_PC) pc <= pc + 12'h1;
    if (clr_DR) dr <= 16'h0; else if (load_DR) dr <= bus; else if (inc_DR) dr <= dr + 16'h1;
    if (clr_AC) ac <= 16'h0; else if (load_AC) ac <= alu_y; else if (inc_AC) ac <= ac + 16'h1;
    if (clr_E) e <= 1'b0; else if (load_E) e <= alu_c; else if (inc_E) e <= ~e;
    if (clr_IR) ir <= 16'h0; else if (load_IR) ir <= bus;
    if (clr_TR) tr <= 16'h0; else if (load_TR) tr <= bus;
    if (clr_IEN) ien <= 1'b0; else if (load_IEN) ien <= 1'b1; else if (inc_IEN) ien <= ~ien;
    if (clr_R) r <= 1'b0; else if (load_R) r <= 1'b1; else if (inc_R) r <= ~r;
    if (clr_start) st <= 1'b0; else if (load_start) st <= bus[0]; else if (inc_start) st <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int k = 0; k < 4096; k++) img[k] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_img = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_img = 1'b0;
    reset = 1'b0;
  endtask

  task automatic next_fetch(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!(sc == 3'd0 && load_AR && mux_sel == 3'd2) && n < 300);
    chk("fetch_reached", 64'(n < 300), 64'(1));
  endtask

  task automatic step_to_sc(input logic [2:0] k);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (sc != k && n < 20);
    chk("sc_reached", 64'(sc), 64'(k));
  endtask

  initial begin
    clear_img();

    // Reset held: all outputs low
    @(negedge clk);
    chk("reset_outputs", 64'({clr_vec, other_vec, sc}), 64'(0));

    // LDA 0x010, HLT, then INC, HLT after resume
    img[12'h000] = 16'h2010;
    img[12'h001] = 16'h7001;
    img[12'h002] = 16'h7020;
    img[12'h003] = 16'h7001;
    img[12'h010] = 16'h1234;
    do_reset();
    #1;
    chk("init_clr", 64'(clr_vec), 64'h3FF);
    chk("init_other", 64'({other_vec, sc}), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_zero", 64'({clr_vec, other_vec, sc}), 64'(0));
    end
    run_req = 1'b1;
    next_fetch(cyc);
    run_req = 1'b0;
    chk("lda_fetch_pc", 64'(pc), 64'h000);
    next_fetch(cyc);
    chk("lda_cycles", 64'(cyc), 64'(6));
    chk("lda_ac", 64'(ac), 64'h1234);
    chk("lda_pc", 64'(pc), 64'h001);
    step_to_sc(3'd3);
    chk("hlt_clr", 64'(clr_vec), 64'h001);
    chk("hlt_other", 64'(other_vec), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("halt_idle", 64'({clr_vec, other_vec, sc}), 64'(0));
    end
    run_req = 1'b1;
    next_fetch(cyc);
    run_req = 1'b0;
    chk("resume_pc", 64'(pc), 64'h002);
    next_fetch(cyc);
    chk("inc_ac", 64'(ac), 64'h1235);

    // CMA then ADD indirect: 0xFFFF + 1
    clear_img();
    img[12'h000] = 16'h7200;
    img[12'h001] = 16'h9005;
    img[12'h002] = 16'h7001;
    img[12'h005] = 16'h0020;
    img[12'h020] = 16'h0001;
    do_reset();
    run_req = 1'b1;
    next_fetch(cyc);
    run_req = 1'b0;
    step_to_sc(3'd3);
    chk("cma_alu", 64'({alu_op, load_AC}), 64'({3'd3, 1'b1}));
    next_fetch(cyc);
    chk("cma_ac", 64'(ac), 64'hFFFF);
    step_to_sc(3'd4);
    chk("add_t4_ar", 64'(ar), 64'h020);
    chk("add_t4_ctl", 64'({mux_sel, load_DR}), 64'({3'd7, 1'b1}));
    step_to_sc(3'd5);
    chk("add_t5_ctl", 64'({alu_op, load_AC, load_E}), 64'({3'd1, 1'b1, 1'b1}));
    next_fetch(cyc);
    chk("add_ac", 64'(ac), 64'h0000);
    chk("add_e", 64'(e), 64'(1));
    chk("add_pc", 64'(pc), 64'h002);

    // ISZ with skip, then ISZ without skip
    clear_img();
    img[12'h000] = 16'h6010;
    img[12'h001] = 16'h7001;
    img[12'h002] = 16'h6011;
    img[12'h003] = 16'h7001;
    img[12'h010] = 16'hFFFF;
    img[12'h011] = 16'h0003;
    do_reset();
    run_req = 1'b1;
    next_fetch(cyc);
    run_req = 1'b0;
    next_fetch(cyc);
    chk("isz_cycles", 64'(cyc), 64'(7));
    chk("isz_mem_wrap", 64'(mem[12'h010]), 64'h0000);
    chk("isz_skip_pc", 64'(pc), 64'h002);
    next_fetch(cyc);
    chk("isz_mem_inc", 64'(mem[12'h011]), 64'h0004);
    chk("isz_noskip_pc", 64'(pc), 64'h003);

    // ION, BUN 0x050, interrupt raised during fetch at 0x050
    clear_img();
    img[12'h000] = 16'hF080;
    img[12'h001] = 16'h4050;
    img[12'h050] = 16'h7020;
    do_reset();
    run_req = 1'b1;
    next_fetch(cyc);
    run_req = 1'b0;
    next_fetch(cyc);
    next_fetch(cyc);
    chk("irq_fetch_pc", 64'(pc), 64'h050);
    chk("irq_ien_set", 64'(ien), 64'(1));
    FGI = 1'b1;
    #1;
    chk("irq_load_r", 64'(load_R), 64'(1));
    step_to_sc(3'd3);
    FGI = 1'b0;
    step_to_sc(3'd0);
    chk("irq_t0_ctl", 64'({load_TR, clr_AR, load_AR, mux_sel}), 64'({1'b1, 1'b1, 1'b0, 3'd2}));
    next_fetch(cyc);
    chk("irq_cycles", 64'(cyc), 64'(3));
    chk("irq_ret_addr", 64'(mem[12'h000]), 64'h0051);
    chk("irq_pc", 64'(pc), 64'h001);
    chk("irq_ien_r", 64'({ien, r}), 64'(0));

    // Reset in the middle of an instruction
    step_to_sc(3'd1);
    reset = 1'b1;
    #1;
    chk("midreset_zero", 64'({clr_vec, other_vec, sc}), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_init", 64'(clr_vec), 64'h3FF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
